// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps at most one block fetch in flight,
// buffers the returned block for decode and flushes on redirect.
module fetch_ctrl #(
  parameter int unsigned CORE_WIDTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [CORE_WIDTH*32-1:0]   imem_rdata_i,
  input  logic                       dec_ready_i,
  input  logic                       redirect_valid_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [31:0]                pc_addr_f,
  output logic [CORE_WIDTH*32-1:0]   instr_blk_f,
  output logic                       fetch_valid_f,
  output logic                       hold_fd
);

  localparam int unsigned BLK_W     = CORE_WIDTH * 32;
  localparam logic [31:0] PC_STRIDE = 32'(4 * CORE_WIDTH);
  localparam logic [BLK_W-1:0] NOP_BLK = {CORE_WIDTH{32'h0000_0013}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // state_q is the observable FSM state for checkers.
  fetch_state_e state_q, state_d;

  logic [31:0]      pc_q;
  logic [31:0]      pc_req_q;
  logic [31:0]      pc_blk_q;
  logic [BLK_W-1:0] blk_q;
  logic             valid_q;

  logic             consume;
  logic             blk_free;
  logic             req_fire;
  logic             fill;
  logic [31:0]      redirect_target;
  logic             unused_redirect_lsbs;

  // Handshake: a request transfers on a cycle where imem_req_o and imem_gnt_i
  // are both high; a response transfers on any cycle imem_rvalid_i is high and
  // is only accepted in WAIT (late/abandoned responses are dropped elsewhere).
  assign hold_fd         = ~dec_ready_i & ~redirect_valid_i;
  assign consume         = valid_q & ~hold_fd;
  assign blk_free        = ~valid_q | consume;
  assign req_fire        = (state_q == REQ) & blk_free & imem_gnt_i;
  assign fill            = (state_q == WAIT) & imem_rvalid_i & ~redirect_valid_i;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = blk_free;
        if (req_fire) begin
          state_d = redirect_valid_i ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
        end else if (redirect_valid_i) begin
          state_d = DROP;
        end
      end
      // A response in DROP always closes the abandoned request, even if a
      // fresh redirect lands on the same cycle.
      DROP: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      pc_req_q <= RESET_PC;
      pc_blk_q <= RESET_PC;
      blk_q    <= NOP_BLK;
      valid_q  <= 1'b0;
    end else begin
      if (redirect_valid_i) begin
        pc_q <= redirect_target;
      end else if (req_fire) begin
        pc_q     <= pc_q + PC_STRIDE;
        pc_req_q <= pc_q;
      end

      if (fill) begin
        blk_q    <= imem_rdata_i;
        pc_blk_q <= pc_req_q;
      end

      if (redirect_valid_i) begin
        valid_q <= 1'b0;
      end else if (fill) begin
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr_o   = pc_q;
  assign fetch_valid_f = valid_q;
  assign instr_blk_f   = valid_q ? blk_q : NOP_BLK;
  assign pc_addr_f     = valid_q ? pc_blk_q : pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stall, redirects and
// mid-flight reset, each with hand-computed expectations.
module tb_fetch_ctrl;

  localparam int unsigned CW    = 2;
  localparam int unsigned BLK_W = CW * 32;
  localparam logic [BLK_W-1:0] NOP_BLK = {CW{32'h0000_0013}};

  logic             clk;
  logic             reset_n;
  logic             imem_req_o;
  logic [31:0]      imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [BLK_W-1:0] imem_rdata_i;
  logic             dec_ready_i;
  logic             redirect_valid_i;
  logic [31:0]      redirect_pc_i;
  logic [31:0]      pc_addr_f;
  logic [BLK_W-1:0] instr_blk_f;
  logic             fetch_valid_f;
  logic             hold_fd;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.CORE_WIDTH(CW), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .dec_ready_i      (dec_ready_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_addr_f        (pc_addr_f),
    .instr_blk_f      (instr_blk_f),
    .fetch_valid_f    (fetch_valid_f),
    .hold_fd          (hold_fd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects a request for addr this cycle; grants it, returns data after lat
  // cycles and checks the block is presented the cycle after rvalid.
  task automatic fetch_block(input logic [31:0] addr, input logic [63:0] data, input int lat);
    chk("req", {63'd0, imem_req_o}, 64'd1);
    chk("addr", {32'd0, imem_addr_o}, {32'd0, addr});
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk("wait_req", {63'd0, imem_req_o}, 64'd0);
    for (int i = 0; i < lat - 1; i++) step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    chk("pre_valid", {63'd0, fetch_valid_f}, 64'd0);
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    chk("valid", {63'd0, fetch_valid_f}, 64'd1);
    chk("pc_blk", {32'd0, pc_addr_f}, {32'd0, addr});
    chk("blk", instr_blk_f, data);
  endtask

  initial begin
    reset_n          = 1'b0;
    imem_gnt_i       = 1'b0;
    imem_rvalid_i    = 1'b0;
    imem_rdata_i     = '0;
    dec_ready_i      = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {63'd0, imem_req_o}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr_o}, 64'd0);
    chk("rst_pc", {32'd0, pc_addr_f}, 64'd0);
    chk("rst_blk", instr_blk_f, NOP_BLK);
    chk("rst_valid", {63'd0, fetch_valid_f}, 64'd0);
    chk("rst_hold", {63'd0, hold_fd}, 64'd0);
    reset_n = 1'b1;
    chk("idle_req", {63'd0, imem_req_o}, 64'd0);
    step();

    // sequential fetch
    fetch_block(32'h0000_0000, 64'h1111_0001_1111_0000, 2);
    fetch_block(32'h0000_0008, 64'h2222_0001_2222_0000, 2);
    fetch_block(32'h0000_0010, 64'h3333_0001_3333_0000, 2);

    // decode stall holds the block and blocks the next request
    dec_ready_i = 1'b0;
    #1;
    chk("stall_hold", {63'd0, hold_fd}, 64'd1);
    chk("stall_req", {63'd0, imem_req_o}, 64'd0);
    step();
    step();
    chk("stall_blk", instr_blk_f, 64'h3333_0001_3333_0000);
    chk("stall_pc", {32'd0, pc_addr_f}, 64'h10);
    chk("stall_req2", {63'd0, imem_req_o}, 64'd0);
    step();
    dec_ready_i = 1'b1;
    #1;
    chk("release_hold", {63'd0, hold_fd}, 64'd0);
    fetch_block(32'h0000_0018, 64'h4444_0001_4444_0000, 1);

    // redirect in WAIT: response dropped, refetch from target
    chk("r1_addr", {32'd0, imem_addr_o}, 64'h20);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i       = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_1003;
    dec_ready_i      = 1'b0;
    #1;
    chk("r1_hold", {63'd0, hold_fd}, 64'd0);
    chk("r1_nop", instr_blk_f, NOP_BLK);
    chk("r1_valid", {63'd0, fetch_valid_f}, 64'd0);
    step();
    redirect_valid_i = 1'b0;
    dec_ready_i      = 1'b1;
    chk("r1_drop_req", {63'd0, imem_req_o}, 64'd0);
    chk("r1_drop_pc", {32'd0, pc_addr_f}, 64'h1000);
    step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    imem_rvalid_i = 1'b0;
    chk("r1_discard", {63'd0, fetch_valid_f}, 64'd0);
    chk("r1_discard_blk", instr_blk_f, NOP_BLK);
    fetch_block(32'h0000_1000, 64'h5555_0001_5555_0000, 2);

    // redirect together with rvalid
    chk("r2_addr", {32'd0, imem_addr_o}, 64'h1008);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    step();
    imem_rvalid_i    = 1'b1;
    imem_rdata_i     = 64'hBAD0_BAD0_BAD0_BAD0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_2000;
    step();
    imem_rvalid_i    = 1'b0;
    redirect_valid_i = 1'b0;
    chk("r2_valid", {63'd0, fetch_valid_f}, 64'd0);
    chk("r2_blk", instr_blk_f, NOP_BLK);
    fetch_block(32'h0000_2000, 64'h6666_0001_6666_0000, 3);

    // redirect overrides a decode stall
    dec_ready_i = 1'b0;
    #1;
    chk("r3_stall", {63'd0, hold_fd}, 64'd1);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_3002;
    #1;
    chk("r3_hold", {63'd0, hold_fd}, 64'd0);
    step();
    redirect_valid_i = 1'b0;
    chk("r3_nop", instr_blk_f, NOP_BLK);
    chk("r3_valid", {63'd0, fetch_valid_f}, 64'd0);
    chk("r3_req", {63'd0, imem_req_o}, 64'd1);
    chk("r3_addr", {32'd0, imem_addr_o}, 64'h3000);
    dec_ready_i = 1'b1;

    // redirect on the grant cycle goes through DROP
    imem_gnt_i       = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_4000;
    step();
    imem_gnt_i       = 1'b0;
    redirect_valid_i = 1'b0;
    chk("r4_drop_req", {63'd0, imem_req_o}, 64'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 64'hCAFE_CAFE_CAFE_CAFE;
    step();
    imem_rvalid_i = 1'b0;
    chk("r4_valid", {63'd0, fetch_valid_f}, 64'd0);
    chk("r4_addr", {32'd0, imem_addr_o}, 64'h4000);

    // reset while a fetch is outstanding, stale response afterwards
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("ar_req", {63'd0, imem_req_o}, 64'd0);
    chk("ar_addr", {32'd0, imem_addr_o}, 64'd0);
    chk("ar_valid", {63'd0, fetch_valid_f}, 64'd0);
    step();
    reset_n       = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 64'hFEED_FEED_FEED_FEED;
    step();
    chk("ar_stale_idle", {63'd0, fetch_valid_f}, 64'd0);
    step();
    imem_rvalid_i = 1'b0;
    chk("ar_stale_req", {63'd0, fetch_valid_f}, 64'd0);
    chk("ar_nop", instr_blk_f, NOP_BLK);
    fetch_block(32'h0000_0000, 64'h7777_0001_7777_0000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
